// File: rtl/boot_image_loader_pkg.sv
// Shared boot-image definitions: copy FSM states, image bounds and the RAM base address.
package boot_image_loader_pkg;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_WRITE = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    localparam logic [7:0]  BOOT_START    = 8'hCC;
    localparam logic [7:0]  BOOT_LAST     = 8'hFD;
    localparam logic [15:0] BOOT_RAM_BASE = 16'hFFCC;
    localparam int unsigned CSUM_W        = 16;

endpackage

// File: rtl/boot_image_loader.sv
// Copies boot ROM words START..LAST into RAM at RAM_BASE, keeping a 16-bit running sum,
// and holds the CPU in reset until the copy completes.
module boot_image_loader
    import boot_image_loader_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 8,
    parameter int unsigned       DATA_W   = 16,
    parameter int unsigned       RAM_AW   = 16,
    parameter logic [ADDR_W-1:0] START    = BOOT_START,
    parameter logic [ADDR_W-1:0] LAST     = BOOT_LAST,
    parameter logic [RAM_AW-1:0] RAM_BASE = BOOT_RAM_BASE
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              restart,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_we,
    input  logic              ram_ack,
    output logic              cpu_hold,
    output logic              done,
    output logic [CSUM_W-1:0] checksum
);

    if (START > LAST) begin : g_bounds_check
        $error("boot_image_loader: START must not exceed LAST");
    end

    state_e              state_q,     state_d;
    logic [ADDR_W-1:0]   rom_addr_q,  rom_addr_d;
    logic [RAM_AW-1:0]   ram_addr_q,  ram_addr_d;
    logic [DATA_W-1:0]   ram_wdata_q, ram_wdata_d;
    logic                ram_we_q,    ram_we_d;
    logic                cpu_hold_q,  cpu_hold_d;
    logic                done_q,      done_d;
    logic [CSUM_W-1:0]   checksum_q,  checksum_d;
    logic [ADDR_W-1:0]   offset;

    always_comb begin
        state_d     = state_q;
        rom_addr_d  = rom_addr_q;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        ram_we_d    = ram_we_q;
        cpu_hold_d  = cpu_hold_q;
        done_d      = done_q;
        checksum_d  = checksum_q;
        offset      = rom_addr_q - START;

        case (state_q)
            ST_FETCH: begin
                ram_wdata_d = rom_data;
                checksum_d  = checksum_q + CSUM_W'(rom_data);
                ram_addr_d  = RAM_BASE + RAM_AW'(offset);
                ram_we_d    = 1'b1;
                state_d     = ST_WRITE;
            end
            ST_WRITE: begin
                // LAST is compared before incrementing so an all-ones LAST never wraps.
                if (ram_ack) begin
                    ram_we_d = 1'b0;
                    if (rom_addr_q == LAST) begin
                        state_d    = ST_DONE;
                        done_d     = 1'b1;
                        cpu_hold_d = 1'b0;
                    end else begin
                        rom_addr_d = rom_addr_q + 1'b1;
                        state_d    = ST_FETCH;
                    end
                end
            end
            ST_DONE: begin
                ram_we_d = 1'b0;
                if (restart) begin
                    checksum_d = '0;
                    done_d     = 1'b0;
                    cpu_hold_d = 1'b1;
                    rom_addr_d = START;
                    state_d    = ST_FETCH;
                end
            end
            default: state_d = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_FETCH;
            rom_addr_q  <= START;
            ram_addr_q  <= RAM_BASE;
            ram_wdata_q <= '0;
            ram_we_q    <= 1'b0;
            cpu_hold_q  <= 1'b1;
            done_q      <= 1'b0;
            checksum_q  <= '0;
        end else begin
            state_q     <= state_d;
            rom_addr_q  <= rom_addr_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            ram_we_q    <= ram_we_d;
            cpu_hold_q  <= cpu_hold_d;
            done_q      <= done_d;
            checksum_q  <= checksum_d;
        end
    end

    assign rom_addr  = rom_addr_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign ram_we    = ram_we_q;
    assign cpu_hold  = cpu_hold_q;
    assign done      = done_q;
    assign checksum  = checksum_q;

endmodule

// File: tb/tb_boot_image_loader.sv
// Scoreboard bench for boot_image_loader: expected RAM writes are queued from a ROM-image
// reference model and popped by an independent monitor on each accepted write.
module tb_boot_image_loader;

    localparam int unsigned IMG_START = 8'hCC;
    localparam int unsigned IMG_LAST  = 8'hFD;
    localparam int unsigned IMG_BASE  = 16'hFFCC;
    localparam int unsigned IMG_WORDS = IMG_LAST - IMG_START + 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, restart, ram_ack;
    logic [7:0]  rom_addr;
    logic [15:0] rom_data, ram_addr, ram_wdata, checksum;
    logic        ram_we, cpu_hold, done;

    logic        reset1, restart1, ram_ack1;
    logic [7:0]  rom_addr1;
    logic [15:0] rom_data1, ram_addr1, ram_wdata1, checksum1;
    logic        ram_we1, cpu_hold1, done1;

    logic [15:0] rom [256];
    assign rom_data  = rom[rom_addr];
    assign rom_data1 = rom[rom_addr1];

    boot_image_loader dut (
        .clk(clk), .reset(reset), .restart(restart),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_ack(ram_ack),
        .cpu_hold(cpu_hold), .done(done), .checksum(checksum)
    );

    boot_image_loader #(.START(8'hFF), .LAST(8'hFF), .RAM_BASE(16'h0000)) dut_one (
        .clk(clk), .reset(reset1), .restart(restart1),
        .rom_addr(rom_addr1), .rom_data(rom_data1),
        .ram_addr(ram_addr1), .ram_wdata(ram_wdata1), .ram_we(ram_we1), .ram_ack(ram_ack1),
        .cpu_hold(cpu_hold1), .done(done1), .checksum(checksum1)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: the image is a plain array copy plus a modular sum.
    typedef struct { logic [15:0] a; logic [15:0] d; } wr_t;
    wr_t         exp_q[$];
    logic [15:0] exp_sum;

    task automatic push_copy();
        int unsigned s;
        wr_t w;
        s = 0;
        for (int unsigned i = IMG_START; i <= IMG_LAST; i++) begin
            w.a = 16'((IMG_BASE + (i - IMG_START)) % 65536);
            w.d = rom[i];
            exp_q.push_back(w);
            s = (s + rom[i]) % 65536;
        end
        exp_sum = 16'(s);
    endtask

    int cyc;
    always @(posedge clk or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    // 0: ack tied high, 1: 3-cycle wait on FFD1, 2: random waits, 3: ack forced high
    int ack_mode = 0;
    initial begin
        int  waits;
        bit  pending;
        ram_ack = 1'b0;
        waits   = 0;
        pending = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (ack_mode == 0 || ack_mode == 3) begin
                ram_ack = 1'b1;
            end else if (ram_we) begin
                if (!pending) begin
                    pending = 1'b1;
                    if (ack_mode == 1) waits = (ram_addr == 16'hFFD1) ? 3 : 0;
                    else               waits = int'($urandom_range(0, 2));
                end else if (waits > 0) begin
                    waits--;
                end
                ram_ack = (waits == 0);
            end else begin
                ram_ack = 1'b0;
            end
            if (ram_ack || !ram_we) pending = 1'b0;
        end
    end

    // Monitor: pops on every accepted write and checks that a stalled write is held.
    bit          hold_chk = 1'b0;
    logic [15:0] hold_a, hold_d;
    always @(negedge clk) begin
        wr_t e;
        if (reset) begin
            hold_chk = 1'b0;
        end else begin
            if (hold_chk) begin
                chk("hold_we", 32'(ram_we), 32'd1);
                chk("hold_addr", 32'(ram_addr), 32'(hold_a));
                chk("hold_data", 32'(ram_wdata), 32'(hold_d));
            end
            if (ram_we && ram_ack) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write: got addr %h data %h expected no write", ram_addr, ram_wdata);
                end else begin
                    e = exp_q.pop_front();
                    if (ram_addr !== e.a || ram_wdata !== e.d) begin
                        errors++;
                        $display("FAIL write: got addr %h data %h expected addr %h data %h",
                                 ram_addr, ram_wdata, e.a, e.d);
                    end
                end
            end
            hold_chk = ram_we && !ram_ack;
            hold_a   = ram_addr;
            hold_d   = ram_wdata;
        end
    end

    task automatic check_reset_vals();
        chk("rst_rom_addr", 32'(rom_addr), 32'(IMG_START));
        chk("rst_ram_addr", 32'(ram_addr), 32'(IMG_BASE));
        chk("rst_ram_wdata", 32'(ram_wdata), 32'd0);
        chk("rst_ram_we", 32'(ram_we), 32'd0);
        chk("rst_cpu_hold", 32'(cpu_hold), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_checksum", 32'(checksum), 32'd0);
    endtask

    task automatic start_copy();
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_reset_vals();
        exp_q.delete();
        push_copy();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (!done && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (!done) chk("done_timeout", 32'(done), 32'd1);
    endtask

    task automatic wait_write_to(input logic [15:0] addr, input int budget);
        int n;
        n = 0;
        while (!(ram_we && ram_addr == addr) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (!(ram_we && ram_addr == addr)) chk("write_wait_timeout", 32'(ram_addr), 32'(addr));
    endtask

    task automatic check_finished();
        chk("done", 32'(done), 32'd1);
        chk("cpu_hold_released", 32'(cpu_hold), 32'd0);
        chk("checksum", 32'(checksum), 32'(exp_sum));
        chk("rom_addr_last", 32'(rom_addr), 32'(IMG_LAST));
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0;
        logic [15:0] snap;
        reset = 1'b1; reset1 = 1'b1;
        restart = 1'b0; restart1 = 1'b0; ram_ack1 = 1'b1;
        for (int i = 0; i < 256; i++) rom[i] = 16'($urandom);
        rom[8'hCC] = 16'h00A2;
        rom[8'hCD] = 16'hFFFF;
        rom[8'hD1] = 16'hA5C3;
        rom[8'hFD] = 16'hFFFF;

        // 1: ack tied high, full copy in 2N cycles
        ack_mode = 0;
        start_copy();
        wait_done(300);
        chk("t1_done_cycle", 32'(cyc), 32'(2 * IMG_WORDS));
        check_finished();

        // 2: FFD1 waits 3 cycles for ack and is held stable for 4
        ack_mode = 1;
        start_copy();
        wait_write_to(16'hFFD1, 200);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("t2_held_we", 32'(ram_we), 32'd1);
            chk("t2_held_data", 32'(ram_wdata), 32'h0000A5C3);
        end
        @(negedge clk);
        chk("t2_we_dropped", 32'(ram_we), 32'd0);
        wait_done(300);
        chk("t2_done_cycle", 32'(cyc), 32'(2 * IMG_WORDS + 3));
        check_finished();

        // 3: reset while writing FFE0, then a full copy after release
        ack_mode = 2;
        start_copy();
        wait_write_to(16'hFFE0, 400);
        #1;
        reset = 1'b1;
        #1;
        check_reset_vals();
        exp_q.delete();
        push_copy();
        @(negedge clk);
        reset = 1'b0;
        wait_done(500);
        check_finished();

        // 4: restart ignored during copy and on the final ack; honoured in DONE
        ack_mode = 2;
        start_copy();
        for (int k = 0; k < 3; k++) begin
            repeat ($urandom_range(5, 20)) @(negedge clk);
            restart = 1'b1;
            @(negedge clk);
            restart = 1'b0;
        end
        ack_mode = 0;
        wait_write_to(16'hFFFD, 400);
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        @(negedge clk);
        check_finished();
        push_copy();
        restart = 1'b1;
        r0 = cyc;
        @(negedge clk);
        restart = 1'b0;
        chk("t4_restart_checksum", 32'(checksum), 32'd0);
        chk("t4_restart_cpu_hold", 32'(cpu_hold), 32'd1);
        chk("t4_restart_done", 32'(done), 32'd0);
        chk("t4_restart_rom_addr", 32'(rom_addr), 32'(IMG_START));
        wait_done(300);
        chk("t4_done_cycle", 32'(cyc), 32'(r0 + 1 + 2 * IMG_WORDS));
        check_finished();

        // 6: ack while idle in DONE changes nothing
        snap = checksum;
        ack_mode = 3;
        repeat (3) begin
            @(negedge clk);
            chk("t6_ram_we", 32'(ram_we), 32'd0);
            chk("t6_checksum", 32'(checksum), 32'(snap));
            chk("t6_done", 32'(done), 32'd1);
            chk("t6_rom_addr", 32'(rom_addr), 32'(IMG_LAST));
        end
        ack_mode = 0;

        // 5: single-word image at the top of ROM
        @(negedge clk);
        chk("t5_rst_rom_addr", 32'(rom_addr1), 32'h000000FF);
        chk("t5_rst_ram_addr", 32'(ram_addr1), 32'd0);
        reset1 = 1'b0;
        @(negedge clk);
        chk("t5_we", 32'(ram_we1), 32'd1);
        chk("t5_addr", 32'(ram_addr1), 32'd0);
        chk("t5_data", 32'(ram_wdata1), 32'(rom[8'hFF]));
        @(negedge clk);
        chk("t5_done_cycle2", 32'(done1), 32'd1);
        chk("t5_cpu_hold", 32'(cpu_hold1), 32'd0);
        chk("t5_we_off", 32'(ram_we1), 32'd0);
        chk("t5_checksum", 32'(checksum1), 32'(rom[8'hFF]));
        repeat (4) begin
            @(negedge clk);
            chk("t5_rom_addr_stays", 32'(rom_addr1), 32'h000000FF);
            chk("t5_no_rewrite", 32'(ram_we1), 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
